// File: rtl/uart_tx_core_if.sv
// rtl/uart_tx_core_if.sv - byte handshake between upstream producer and uart_tx_core
interface uart_tx_core_if;
    logic [7:0] i_Data;
    logic       i_Valid;
    logic       o_Ready;

    modport master (output i_Data, output i_Valid, input o_Ready);
    modport slave  (input i_Data, input i_Valid, output o_Ready);
endinterface

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 UART transmitter, one byte per valid/ready handshake
module uart_tx_core #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic           Clk,
    input  logic           Rst,
    uart_tx_core_if.slave  s,
    output logic           o_Tx,
    output logic           o_Busy,
    output logic           o_Done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_core: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // tx_d always carries the line level for the state being entered, so o_Tx is a pure flop output
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (s.i_Valid) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = s.i_Data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign s.o_Ready = (state_q == IDLE);
    assign o_Busy    = (state_q != IDLE);
    assign o_Tx      = tx_q;
    assign o_Done    = done_q;
endmodule
